// File: rtl/key_conditioner_pkg.sv
// rtl/key_conditioner_pkg.sv - shared state encodings, defaults and helpers for the key conditioner
package key_conditioner_pkg;

    typedef enum logic [1:0] {
        KC_RELEASED    = 2'd0,
        KC_HELD_DELAY  = 2'd1,
        KC_HELD_REPEAT = 2'd2
    } kc_state_e;

    // Raw keys are active-low, so an idle (released) key reads as 1.
    localparam logic KC_KEY_IDLE = 1'b1;

    localparam int KC_DEF_N_KEYS          = 2;
    localparam int KC_DEF_DEBOUNCE_CYCLES = 4;
    localparam int KC_DEF_REPEAT_EN       = 1;
    localparam int KC_DEF_REPEAT_DELAY    = 8;
    localparam int KC_DEF_REPEAT_PERIOD   = 3;

    function automatic int kc_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one key channel: synchronizer, debounce filter, press detect and auto-repeat
module key_debounce
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KC_DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN       = KC_DEF_REPEAT_EN,
    parameter int REPEAT_DELAY    = KC_DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = KC_DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_level,
    output logic press_pulse
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RCNT_W = $clog2(kc_max(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

    logic              s1;
    logic              s2;
    logic              deb_n;
    logic [CNT_W-1:0]  cnt;
    logic              flip;
    logic              press_evt;
    logic              release_evt;

    kc_state_e         state;
    kc_state_e         state_d;
    logic [RCNT_W-1:0] rcnt;
    logic [RCNT_W-1:0] rcnt_d;
    logic              pulse_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= KC_KEY_IDLE;
            s2 <= KC_KEY_IDLE;
        end else begin
            s1 <= key_n;
            s2 <= s1;
        end
    end

    // The flip fires on the DEBOUNCE_CYCLES-th consecutive differing sample, so the
    // FSM sees the accepted edge in the same cycle the debounced state updates.
    assign flip        = (s2 != deb_n) && (cnt == CNT_LAST);
    assign press_evt   = flip && !s2;
    assign release_evt = flip && s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_n <= KC_KEY_IDLE;
            cnt   <= '0;
        end else if (s2 == deb_n) begin
            cnt <= '0;
        end else if (flip) begin
            deb_n <= s2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign key_level = ~deb_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= KC_RELEASED;
            rcnt        <= '0;
            press_pulse <= 1'b0;
        end else begin
            state       <= state_d;
            rcnt        <= rcnt_d;
            press_pulse <= pulse_d;
        end
    end

    // Release is checked before any repeat so a release wins a same-cycle repeat.
    always_comb begin
        state_d = state;
        rcnt_d  = rcnt;
        pulse_d = 1'b0;
        unique case (state)
            KC_RELEASED: begin
                if (press_evt) begin
                    state_d = KC_HELD_DELAY;
                    rcnt_d  = '0;
                    pulse_d = 1'b1;
                end
            end
            KC_HELD_DELAY: begin
                if (release_evt) begin
                    state_d = KC_RELEASED;
                    rcnt_d  = '0;
                end else if (REPEAT_EN != 0) begin
                    if (rcnt == DELAY_LAST) begin
                        state_d = KC_HELD_REPEAT;
                        rcnt_d  = '0;
                        pulse_d = 1'b1;
                    end else begin
                        rcnt_d = rcnt + RCNT_W'(1);
                    end
                end
            end
            KC_HELD_REPEAT: begin
                if (release_evt) begin
                    state_d = KC_RELEASED;
                    rcnt_d  = '0;
                end else if (rcnt == PERIOD_LAST) begin
                    rcnt_d  = '0;
                    pulse_d = 1'b1;
                end else begin
                    rcnt_d = rcnt + RCNT_W'(1);
                end
            end
            default: begin
                state_d = KC_RELEASED;
                rcnt_d  = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - push-button front end: N_KEYS independent debounced press/repeat channels
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int N_KEYS          = KC_DEF_N_KEYS,
    parameter int DEBOUNCE_CYCLES = KC_DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN       = KC_DEF_REPEAT_EN,
    parameter int REPEAT_DELAY    = KC_DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = KC_DEF_REPEAT_PERIOD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_deb (
            .clk         (clk),
            .rst         (rst),
            .key_n       (key_n[i]),
            .key_level   (key_level[i]),
            .press_pulse (press_pulse[i])
        );
    end

endmodule
